// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the single-issue MIPS pipeline.
//
// Holds the PC, fetches one word per request from instruction memory over a
// req/ack handshake and loads the IF/ID pipeline register. A one-entry skid
// buffer catches a word that is acked while downstream is stalled.
//
// Optional feature macro: IF_ACK_TIMEOUT_EN
//   defined   : a wait counter sends the stage to ERROR (sticky fetch_err)
//               after TIMEOUT_CYCLES consecutive un-acked FETCH cycles.
//   undefined : no counter, fetch_err tied to 0, FETCH waits forever.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req          fetch request (high only in FETCH)
//   imem_addr         fetch byte address (always equals the PC)
//   imem_rdata        instruction word, valid with imem_ack
//   imem_ack          completes the fetch in the same cycle
//   stall             IF/ID must hold its contents
//   branch_taken      redirect PC to branch_target and flush IF/ID
//   branch_target     redirect address (bits [1:0] ignored)
//   ifid_valid/instr/pc4  IF/ID pipeline register
//   op                ifid_instr[31:26], combinational
//   fetch_err         sticky fetch-timeout flag
//   dbg_state         current FSM state (IDLE=0, FETCH=1, HOLD=2, ERROR=3)
//
// Handshake: a fetch transfers on a rising edge where imem_req and imem_ack
// are both 1; imem_ack while imem_req=0 is ignored, and the request stays
// high with a stable address until it is acked, redirected or reset.

module if_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  op,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] pc_plus4;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fetch_err_q, fetch_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_d       = skid_q;
`ifdef IF_ACK_TIMEOUT_EN
    tmo_d        = tmo_q;
    fetch_err_d  = fetch_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
`ifdef IF_ACK_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_FETCH: begin
        if (imem_ack) begin
          pc_d = pc_plus4;
`ifdef IF_ACK_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
          end
        end else begin
          if (!stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'd0;
          end
`ifdef IF_ACK_TIMEOUT_EN
          tmo_d = tmo_q + 1'b1;
          // This wait cycle is the TIMEOUT_CYCLES-th one.
          if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d      = S_ERROR;
            fetch_err_d  = 1'b1;
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'd0;
          end
`endif
        end
      end
      S_HOLD: begin
        if (!stall) begin
          // PC already advanced past the skidded word, so its pc4 is pc_q.
          ifid_valid_d = 1'b1;
          ifid_instr_d = skid_q;
          ifid_pc4_d   = pc_q;
          state_d      = S_FETCH;
`ifdef IF_ACK_TIMEOUT_EN
          tmo_d        = '0;
`endif
        end
      end
      default: begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = 32'd0;
      end
    endcase

    // Redirect wins over stall and over any same-cycle ack.
    if (branch_taken && (state_q != S_ERROR)) begin
      pc_d         = {branch_target[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      ifid_instr_d = 32'd0;
      ifid_pc4_d   = 32'd0;
      skid_d       = 32'd0;
      state_d      = S_FETCH;
`ifdef IF_ACK_TIMEOUT_EN
      tmo_d        = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      skid_q       <= 32'd0;
`ifdef IF_ACK_TIMEOUT_EN
      tmo_q        <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      skid_q       <= skid_d;
`ifdef IF_ACK_TIMEOUT_EN
      tmo_q        <= tmo_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign op         = ifid_instr_q[31:26];
  assign dbg_state  = state_q;
`ifdef IF_ACK_TIMEOUT_EN
  assign fetch_err  = fetch_err_q;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the single-issue MIPS pipeline. It holds the PC, issues word fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It drives the 6-bit opcode consumed by the main control unit (`Op`). Stall and branch redirect arrive from downstream.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word aligned.
- `TIMEOUT_CYCLES`, 15: maximum wait cycles for `imem_ack`. Used only when `IF_ACK_TIMEOUT_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous reset, active-high.
- `imem_req`, out, 1: fetch request; held until acked.
- `imem_addr`, out, 32: byte address of the fetch; equals `pc`.
- `imem_rdata`, in, 32: instruction word; valid only when `imem_ack`=1.
- `imem_ack`, in, 1: completes the fetch in the same cycle; ignored when `imem_req`=0.
- `stall`, in, 1: IF/ID must hold its contents.
- `branch_taken`, in, 1: redirect the PC and flush IF/ID.
- `branch_target`, in, 32: redirect address; bits [1:0] forced to 0.
- `ifid_valid`, out, 1: IF/ID holds a real instruction.
- `ifid_instr`, out, 32: fetched instruction (0 = NOP when invalid).
- `ifid_pc4`, out, 32: address of the instruction + 4.
- `op`, out, 6: `ifid_instr[31:26]`, combinational, to the control unit.
- `fetch_err`, out, 1: sticky fetch-timeout flag.

## Operation
States: IDLE, FETCH, HOLD, ERROR.

- **Reset:** `pc`=`RESET_PC`, state=IDLE, `imem_req`=0. `ifid_valid`, `ifid_instr`, `ifid_pc4`, skid buffer, timeout counter and `fetch_err` are all 0.
- **IDLE:** `imem_req`=0; moves to FETCH unconditionally on the next cycle.
- **FETCH:** `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ack` & !`stall`: IF/ID loads `{valid=1, instr=imem_rdata, pc4=pc+4}`; `pc`+=4; stay in FETCH.
  - `imem_ack` & `stall`: the word goes into the skid buffer; `pc`+=4; go to HOLD. IF/ID is unchanged.
  - !`imem_ack` & !`stall`: IF/ID gets a bubble (`valid`=0, `instr`=0).
  - !`imem_ack` & `stall`: IF/ID is unchanged.
- **HOLD:** `imem_req`=0. IF/ID holds while `stall`=1. When `stall`=0, the skid buffer moves into IF/ID and the state returns to FETCH.
- **Branch priority (overrides all of the above, any state except ERROR):**
  - `pc` = `{branch_target[31:2],2'b00}`.
  - IF/ID is cleared (`valid`=0, `instr`=0, `pc4`=0); skid buffer discarded; state = FETCH.
  - An `imem_ack` arriving in the same cycle is discarded.
  - `branch_taken` overrides `stall` for the IF/ID flush.
- **Arithmetic:** PC increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. `pc[1:0]` is always 0.
- **ERROR:** `imem_req`=0, `ifid_valid`=0, `fetch_err`=1. Only `rst` exits this state.
- `rst` asserted mid-fetch abandons the request. `imem_req` is 0 in the following cycle.

## Timing
- `rst` is sampled high at edge E0 and low at E1. Then `imem_req`=1 from E2 with `imem_addr`=`RESET_PC`.
- Fetch latency: ack in cycle N gives `ifid_valid`=1 after edge N+1. With zero-wait memory, throughput is 1 instruction/cycle.
- `op` follows `ifid_instr` with no register stage.
- Branch: `branch_taken` sampled at edge B gives `ifid_valid`=0 and `imem_addr`=target after B. The first target instruction can be in IF/ID after B+1.
- After leaving HOLD, the next `imem_req` rises one cycle later (the HOLD→FETCH edge).

## Configuration
`IF_ACK_TIMEOUT_EN`:
- **Defined:**
  - A counter increments each FETCH cycle with `imem_req`=1 and `imem_ack`=0.
  - It clears on ack, on branch, and on entry to FETCH.
  - When it reaches `TIMEOUT_CYCLES`, the block goes to ERROR and sets `fetch_err`.
- **Undefined:** no counter exists, `fetch_err` is tied to 0, and FETCH waits for `imem_ack` indefinitely.

## Test plan
1. **Reset and stream:** release reset, zero-wait memory returning addr-based words → `imem_addr` 0,4,8… from cycle 2; `ifid_pc4` = addr+4; `op` = instr[31:26] (e.g. 32'h8C22_0004 → `op`=6'b100011).
2. **Stall during ack:** assert `stall` for 3 cycles as 32'h2001_0005 is acked → state HOLD, `imem_req`=0, IF/ID unchanged. After `stall` drops, IF/ID = 32'h2001_0005 and the next fetch address is +4.
3. **Branch with simultaneous ack and stall:** `branch_taken`=1, target 32'h0000_0043 → `pc`=32'h0000_0040; `ifid_valid`=0, `ifid_instr`=0; the acked word is dropped.
4. **Wrap:** `RESET_PC`=32'hFFFF_FFFC → second fetch address 32'h0000_0000; `ifid_pc4`=0 for the first instruction.
5. **Timeout (`IF_ACK_TIMEOUT_EN`, `TIMEOUT_CYCLES`=15):** withhold ack → after 15 waiting cycles `fetch_err`=1 and `imem_req`=0; `rst` clears it. With the macro undefined, the same stimulus keeps `imem_req`=1 and `fetch_err`=0 indefinitely.
6. **Reset mid-wait:** assert `rst` during FETCH with no ack → all outputs return to reset values after the sampling edge.
